// File: rtl/issue_scheduler.sv
// Age-matrix issue scheduler: picks the oldest ready entry whose execution unit can
// accept it, and tracks occupancy of non-pipelined units with per-unit busy counters.
module issue_scheduler #(
    parameter int                DEPTH        = 8,
    parameter int                ADDR_WIDTH   = $clog2(DEPTH),
    parameter int                NUM_EU       = 4,
    parameter int                EUID_W       = $clog2(NUM_EU),
    parameter int                MC_LAT       = 4,
    parameter logic [NUM_EU-1:0] NONPIPE_MASK = NUM_EU'(4'b1000)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DEPTH-1:0]          req,
    input  logic [DEPTH*EUID_W-1:0]   euid,
    input  logic                      alloc_valid,
    input  logic [ADDR_WIDTH-1:0]     alloc_idx,
    input  logic [NUM_EU-1:0]         eu_ready,
    input  logic                      flush,
    output logic                      ren,
    output logic [ADDR_WIDTH-1:0]     raddr,
    output logic [EUID_W-1:0]         issue_euid,
    output logic [NUM_EU-1:0]         eu_busy
);

    localparam int CNT_W = $clog2(MC_LAT + 1);

    logic [DEPTH-1:0]      older_reg [DEPTH];
    logic [EUID_W-1:0]     euid_of   [DEPTH];
    logic [NUM_EU-1:0]     avail;
    logic [DEPTH-1:0]      elig;
    logic [DEPTH-1:0]      win;
    logic [DEPTH-1:0]      sel_vec;
    logic [ADDR_WIDTH-1:0] pick_idx;

    genvar gi;

    assign avail = eu_ready & ~eu_busy;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign euid_of[gi] = euid[gi*EUID_W +: EUID_W];
            assign elig[gi]    = req[gi] & avail[euid_of[gi]];
        end
    endgenerate

    // An eligible entry wins unless another eligible entry is older, or is
    // unordered relative to it and has a lower index.
    always_comb begin
        win = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = elig[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig[j]) begin
                    if (older_reg[j][i] || (!older_reg[i][j] && j < i)) begin
                        win[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Fall back to the lowest eligible index should the matrix ever hold a cycle,
    // so exactly one entry issues whenever any is eligible.
    assign sel_vec = (|win) ? win : elig;

    always_comb begin
        pick_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                pick_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign ren        = rst & ~flush & (|elig);
    assign raddr      = ren ? pick_idx : '0;
    assign issue_euid = ren ? euid_of[pick_idx] : '0;

    // New entry becomes youngest: its row clears, every other row marks it younger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_reg[i] <= '0;
            end
        end else if (alloc_valid) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ADDR_WIDTH'(j) == alloc_idx) begin
                    older_reg[j] <= '0;
                end else begin
                    older_reg[j][alloc_idx] <= 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_EU; gi++) begin : g_eu
            if (NONPIPE_MASK[gi]) begin : g_np
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;

                always_comb begin
                    cnt_next = cnt_reg;
                    if (flush) begin
                        cnt_next = '0;
                    end else if (ren && issue_euid == EUID_W'(gi)) begin
                        cnt_next = CNT_W'(MC_LAT - 1);
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign eu_busy[gi] = (cnt_reg != '0);
            end else begin : g_pipe
                assign eu_busy[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: age ordering, unit availability, busy timing,
// flush and asynchronous reset, with hand-computed expectations.
module tb_issue_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [15:0] euid;
    logic        alloc_valid;
    logic [2:0]  alloc_idx;
    logic [3:0]  eu_ready;
    logic        flush;
    logic        ren;
    logic [2:0]  raddr;
    logic [1:0]  issue_euid;
    logic [3:0]  eu_busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .euid        (euid),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .eu_ready    (eu_ready),
        .flush       (flush),
        .ren         (ren),
        .raddr       (raddr),
        .issue_euid  (issue_euid),
        .eu_busy     (eu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_euid(input int idx, input logic [1:0] val);
        euid[idx*2 +: 2] = val;
    endtask

    task automatic do_alloc(input logic [2:0] idx);
        alloc_valid = 1'b1;
        alloc_idx   = idx;
        tick();
        alloc_valid = 1'b0;
        alloc_idx   = '0;
    endtask

    task automatic expect_issue(input string tag, input logic exp_ren,
                                input int exp_addr, input int exp_eu);
        check({tag, ".ren"},   ren,        exp_ren);
        check({tag, ".raddr"}, raddr,      exp_addr);
        check({tag, ".euid"},  issue_euid, exp_eu);
    endtask

    initial begin
        rst         = 1'b0;
        req         = '0;
        euid        = '0;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        eu_ready    = 4'b1111;
        flush       = 1'b0;

        // Held in reset with requests present: no issue, nothing busy.
        tick();
        req = 8'b0010_0100;
        settle();
        expect_issue("reset", 1'b0, 0, 0);
        check("reset.busy", eu_busy, 0);
        tick();
        rst = 1'b1;
        settle();

        // Empty age matrix: lowest index wins the tie.
        expect_issue("tie", 1'b1, 2, 0);
        check("tie.busy", eu_busy, 0);
        req = '0;
        settle();
        expect_issue("idle", 1'b0, 0, 0);

        // Allocation order 5,1,3 defines age order.
        set_euid(5, 2'd0);
        set_euid(1, 2'd1);
        set_euid(3, 2'd2);
        do_alloc(3'd5);
        do_alloc(3'd1);
        do_alloc(3'd3);
        req = 8'b0010_1010;
        settle();
        expect_issue("age0", 1'b1, 5, 0);
        req = 8'b0000_1010;
        settle();
        expect_issue("age1", 1'b1, 1, 1);
        req = 8'b0000_1000;
        settle();
        expect_issue("age2", 1'b1, 3, 2);
        req = '0;

        // Oldest entry's unit not ready: younger eligible entry goes first.
        set_euid(4, 2'd3);
        set_euid(6, 2'd0);
        set_euid(7, 2'd3);
        do_alloc(3'd4);
        do_alloc(3'd6);
        do_alloc(3'd7);
        eu_ready = 4'b0111;
        req      = 8'b0101_0000;
        settle();
        expect_issue("notready", 1'b1, 6, 0);
        eu_ready = 4'b1111;
        settle();
        expect_issue("ready", 1'b1, 4, 3);

        // Non-pipelined unit 3 occupancy: issue at t, next unit-3 issue at t+4.
        req = 8'b1001_0000;
        settle();
        expect_issue("np_t0", 1'b1, 4, 3);
        tick();
        req = 8'b1000_0000;
        settle();
        check("np_t1.busy", eu_busy, 8);
        check("np_t1.ren", ren, 0);
        tick();
        check("np_t2.busy", eu_busy, 8);
        check("np_t2.ren", ren, 0);
        tick();
        check("np_t3.busy", eu_busy, 8);
        check("np_t3.ren", ren, 0);
        tick();
        check("np_t4.busy", eu_busy, 0);
        expect_issue("np_t4", 1'b1, 7, 3);
        tick();

        // Flush blocks issue this cycle and clears busy at the edge.
        req   = 8'b0100_0000;
        flush = 1'b1;
        settle();
        check("flush.busy", eu_busy, 8);
        check("flush.ren", ren, 0);
        tick();
        flush = 1'b0;
        settle();
        check("postflush.busy", eu_busy, 0);
        expect_issue("postflush", 1'b1, 6, 0);

        // Asynchronous reset with counter at 2 clears busy and ren immediately.
        req = 8'b0001_0000;
        settle();
        expect_issue("arst_iss", 1'b1, 4, 3);
        tick();
        req = '0;
        tick();
        req = 8'b0100_0000;
        settle();
        check("arst_pre.busy", eu_busy, 8);
        check("arst_pre.ren", ren, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst.busy", eu_busy, 0);
        expect_issue("arst", 1'b0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 8'b0101_0000;
        settle();
        check("postrst.busy", eu_busy, 0);
        expect_issue("postrst", 1'b1, 4, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
